// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit
//   Multi-cycle MIPS main control FSM. Decodes R-type, lw, sw, beq, j and
//   (optionally) addi. It steps each instruction through fetch, decode,
//   execute, memory and write-back, and drives the datapath controls.
//
// Parameters
//   INSTR_WIDTH  instruction width; the opcode is the top 6 bits
//   MEM_WAIT_EN  1: memory states wait for MemReady; 0: one-cycle memory
//   ADDI_EN      1: decode addi; 0: addi traps as illegal
//   COUNT_WIDTH  width of RetireCount (wraps)
//
// Ports
//   CLK, Reset              clock, synchronous active-high reset
//   Instr, Zero, MemReady   instruction register, ALU zero flag, memory done
//   PCWrite, PCSrc          PC load enable and PC source select
//   IorD, IRWrite           memory address select, instruction register load
//   MemRead, MemWrite       memory strobes
//   MemtoReg, RegDst        write-back data and register selects
//   RegWrite                register-file write enable
//   ALUSrcA, ALUSrcB, ALUOp ALU operand and operation selects
//   Busy, IllegalOp, State  status: not in FETCH, sticky trap flag, state code
//   RetireCount             completed-instruction counter
module multicycle_control_unit #(
   parameter int unsigned INSTR_WIDTH = 32,
   parameter int unsigned MEM_WAIT_EN = 1,
   parameter int unsigned ADDI_EN     = 1,
   parameter int unsigned COUNT_WIDTH = 16
) (
   input  logic                   CLK,
   input  logic                   Reset,
   input  logic [INSTR_WIDTH-1:0] Instr,
   input  logic                   Zero,
   input  logic                   MemReady,
   output logic                   PCWrite,
   output logic [1:0]             PCSrc,
   output logic                   IorD,
   output logic                   IRWrite,
   output logic                   MemRead,
   output logic                   MemWrite,
   output logic                   MemtoReg,
   output logic                   RegDst,
   output logic                   RegWrite,
   output logic                   ALUSrcA,
   output logic [1:0]             ALUSrcB,
   output logic [1:0]             ALUOp,
   output logic                   Busy,
   output logic                   IllegalOp,
   output logic [3:0]             State,
   output logic [COUNT_WIDTH-1:0] RetireCount
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_ALUWB  = 4'd7,
      S_BRANCH = 4'd8,
      S_ADDIEX = 4'd9,
      S_ADDIWB = 4'd10,
      S_JUMP   = 4'd11,
      S_TRAP   = 4'd12
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   state_t                 state_q, state_d;
   logic [5:0]             op_q;
   logic                   ill_q;
   logic [COUNT_WIDTH-1:0] cnt_q;
   logic [5:0]             opcode;
   logic                   done;
   logic                   retire;

   assign opcode = Instr[INSTR_WIDTH-1 -: 6];
   assign done   = (MEM_WAIT_EN != 0) ? MemReady : 1'b1;

   always_comb begin
      state_d  = state_q;
      retire   = 1'b0;
      PCWrite  = 1'b0;
      PCSrc    = 2'b00;
      IorD     = 1'b0;
      IRWrite  = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      MemtoReg = 1'b0;
      RegDst   = 1'b0;
      RegWrite = 1'b0;
      ALUSrcA  = 1'b0;
      ALUSrcB  = 2'b00;
      ALUOp    = 2'b00;
      // Under reset every control stays at its zero default, so an aborted
      // instruction can never write the PC, register file or memory.
      if (!Reset) begin
         case (state_q)
            S_FETCH: begin
               MemRead = 1'b1;
               ALUSrcB = 2'b01;
               IRWrite = done;
               PCWrite = done;
               if (done) state_d = S_DECODE;
            end
            S_DECODE: begin
               ALUSrcB = 2'b11;
               case (opcode)
                  OP_RTYPE:     state_d = S_EXEC;
                  OP_LW, OP_SW: state_d = S_MEMADR;
                  OP_BEQ:       state_d = S_BRANCH;
                  OP_J:         state_d = S_JUMP;
                  OP_ADDI:      state_d = (ADDI_EN != 0) ? S_ADDIEX : S_TRAP;
                  default:      state_d = S_TRAP;
               endcase
            end
            S_MEMADR: begin
               ALUSrcA = 1'b1;
               ALUSrcB = 2'b10;
               state_d = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
               IorD    = 1'b1;
               MemRead = 1'b1;
               if (done) state_d = S_MEMWB;
            end
            S_MEMWB: begin
               MemtoReg = 1'b1;
               RegWrite = 1'b1;
               retire   = 1'b1;
               state_d  = S_FETCH;
            end
            S_MEMWR: begin
               IorD     = 1'b1;
               MemWrite = 1'b1;
               if (done) begin
                  retire  = 1'b1;
                  state_d = S_FETCH;
               end
            end
            S_EXEC: begin
               ALUSrcA = 1'b1;
               ALUOp   = 2'b10;
               state_d = S_ALUWB;
            end
            S_ALUWB: begin
               RegDst   = 1'b1;
               RegWrite = 1'b1;
               retire   = 1'b1;
               state_d  = S_FETCH;
            end
            S_BRANCH: begin
               ALUSrcA = 1'b1;
               ALUOp   = 2'b01;
               PCSrc   = 2'b01;
               PCWrite = Zero;
               retire  = 1'b1;
               state_d = S_FETCH;
            end
            S_ADDIEX: begin
               ALUSrcA = 1'b1;
               ALUSrcB = 2'b10;
               state_d = S_ADDIWB;
            end
            S_ADDIWB: begin
               RegWrite = 1'b1;
               retire   = 1'b1;
               state_d  = S_FETCH;
            end
            S_JUMP: begin
               PCSrc   = 2'b10;
               PCWrite = 1'b1;
               retire  = 1'b1;
               state_d = S_FETCH;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_FETCH;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (Reset) begin
         state_q <= S_FETCH;
         op_q    <= '0;
         ill_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == S_DECODE) op_q <= opcode;
         if (state_d == S_TRAP) ill_q <= 1'b1;
         if (retire) cnt_q <= cnt_q + COUNT_WIDTH'(1);
      end
   end

   assign Busy        = (state_q != S_FETCH);
   assign IllegalOp   = ill_q;
   assign State       = state_q;
   assign RetireCount = cnt_q;

endmodule
